// File: rtl/decode_stage_pipelined.sv
// Instruction-decode pipeline stage: classifies raw words into formats a/b/c,
// extracts fields and the extended immediate, and buffers results in a 2-entry skid buffer.
module decode_stage_pipelined #(
   parameter int              DATA_W   = 32,
   parameter int              REG_W    = 5,
   parameter int              OP_W     = 6,
   parameter logic [OP_W-1:0] IMM_OP0  = 6'h22,
   parameter logic [OP_W-1:0] IMM_OP1  = 6'h23,
   parameter logic [OP_W-1:0] RSV_LO   = 6'h30,
   parameter logic [OP_W-1:0] RSV_HI   = 6'h3E,
   parameter int              SIGN_EXT = 1,
   parameter int              CNT_W    = 16
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           flush,
   input  logic                           in_valid,
   output logic                           in_ready,
   input  logic [DATA_W-1:0]              in_instr,
   output logic                           out_valid,
   input  logic                           out_ready,
   output logic [1:0]                     out_format,
   output logic [REG_W-1:0]               out_rs1,
   output logic [REG_W-1:0]               out_rs2,
   output logic [REG_W-1:0]               out_rd,
   output logic [OP_W-1:0]                out_opcode,
   output logic [DATA_W-3*REG_W-OP_W-1:0] out_funct,
   output logic [DATA_W-1:0]              out_imm,
   output logic                           out_nop,
   output logic                           out_ifnr,
   output logic [CNT_W-1:0]               retired_cnt
);

   localparam int FN_W   = DATA_W - 3*REG_W - OP_W;
   localparam int IMMB_W = DATA_W - 2*REG_W - OP_W;
   localparam int IMMC_W = DATA_W - OP_W;

   typedef struct packed {
      logic [1:0]        fmt;
      logic [REG_W-1:0]  rs1;
      logic [REG_W-1:0]  rs2;
      logic [REG_W-1:0]  rd;
      logic [OP_W-1:0]   op;
      logic [FN_W-1:0]   fn;
      logic [DATA_W-1:0] imm;
      logic              nop;
      logic              ifnr;
   } ent_t;

   function automatic logic [DATA_W-1:0] ext_b(input logic [IMMB_W-1:0] f);
      logic signed [DATA_W-1:0] v;
      if (SIGN_EXT != 0) v = DATA_W'($signed(f));
      else               v = DATA_W'(f);
      return v;
   endfunction

   function automatic logic [DATA_W-1:0] ext_c(input logic [IMMC_W-1:0] f);
      logic signed [DATA_W-1:0] v;
      if (SIGN_EXT != 0) v = DATA_W'($signed(f));
      else               v = DATA_W'(f);
      return v;
   endfunction

   logic [OP_W-1:0]  w_op;
   ent_t             w_dec;
   logic             w_push;
   logic             w_pop;
   ent_t             r_ent0;
   ent_t             r_ent1;
   logic [1:0]       r_cnt;
   logic [CNT_W-1:0] r_ret;

   assign w_op = in_instr[OP_W-1:0];

   always_comb begin
      w_dec      = '0;
      w_dec.op   = w_op;
      w_dec.nop  = &w_op;
      // An all-ones opcode is a NOP even if it falls inside the reserved range.
      w_dec.ifnr = (w_op >= RSV_LO) && (w_op <= RSV_HI) && !(&w_op);
      if (w_op == '0) begin
         w_dec.fmt = 2'd0;
         w_dec.rs1 = in_instr[DATA_W-1 -: REG_W];
         w_dec.rs2 = in_instr[DATA_W-REG_W-1 -: REG_W];
         w_dec.rd  = in_instr[DATA_W-2*REG_W-1 -: REG_W];
         w_dec.fn  = in_instr[DATA_W-3*REG_W-1:OP_W];
      end else if ((w_op == IMM_OP0) || (w_op == IMM_OP1)) begin
         w_dec.fmt = 2'd1;
         w_dec.rs1 = in_instr[DATA_W-1 -: REG_W];
         w_dec.rd  = in_instr[DATA_W-REG_W-1 -: REG_W];
         w_dec.imm = ext_b(in_instr[DATA_W-2*REG_W-1:OP_W]);
      end else begin
         w_dec.fmt = 2'd2;
         w_dec.imm = ext_c(in_instr[DATA_W-1:OP_W]);
      end
   end

   assign in_ready  = (r_cnt != 2'd2);
   assign out_valid = (r_cnt != 2'd0);
   assign w_push    = in_valid && in_ready;
   assign w_pop     = out_valid && out_ready;

   // Buffer stage: entry 0 is always the head, entry 1 is the skid slot.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt  <= 2'd0;
         r_ent0 <= '0;
         r_ent1 <= '0;
         r_ret  <= '0;
      end else begin
         if (w_pop && !r_ent0.nop && !flush) r_ret <= r_ret + CNT_W'(1);
         if (flush) begin
            r_cnt <= 2'd0;
         end else begin
            case (r_cnt)
               2'd0: begin
                  if (w_push) begin
                     r_ent0 <= w_dec;
                     r_cnt  <= 2'd1;
                  end
               end
               2'd1: begin
                  case ({w_push, w_pop})
                     2'b11: r_ent0 <= w_dec;
                     2'b10: begin
                        r_ent1 <= w_dec;
                        r_cnt  <= 2'd2;
                     end
                     2'b01: r_cnt <= 2'd0;
                     default: ;
                  endcase
               end
               default: begin
                  if (w_pop) begin
                     r_ent0 <= r_ent1;
                     r_cnt  <= 2'd1;
                  end
               end
            endcase
         end
      end
   end

   assign out_format  = r_ent0.fmt;
   assign out_rs1     = r_ent0.rs1;
   assign out_rs2     = r_ent0.rs2;
   assign out_rd      = r_ent0.rd;
   assign out_opcode  = r_ent0.op;
   assign out_funct   = r_ent0.fn;
   assign out_imm     = r_ent0.imm;
   assign out_nop     = r_ent0.nop;
   assign out_ifnr    = r_ent0.ifnr;
   assign retired_cnt = r_ret;

endmodule
